raster_tri_walker: RTL and testbench

Per-triangle pixel iterator that sits directly downstream of triangle setup and upstream of fragment shading/depth.
- Accepts one triangle per handshake: a screen-space bounding box plus three edge-function coefficient sets.
- Scans the box in raster order and evaluates the edge functions incrementally, one pixel per cycle.
- Emits the (x,y) of every covered pixel over a valid/ready stream.

---
 rtl/raster_tri_walker.sv | 163 ++++++++++++++++
 tb/tb_raster_tri_walker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/raster_tri_walker.sv
// raster_tri_walker: per-triangle pixel iterator between triangle setup and fragment shading.
// Takes one triangle at a time: a bounding box plus three edge functions.
// Scans the box in raster order, y outer and x inner, one pixel per cycle.
// Each edge function is updated incrementally as the scan moves.
// Only covered pixels are emitted.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   vld_in / rdy_in    triangle descriptor handshake
//   xmin..ymax         inclusive bounding box (unsigned)
//   a0..b2             signed per-edge x/y step coefficients (COEF_W)
//   c0..c2             signed edge constants (ACC_W)
//   vld_out / rdy_out  covered-pixel stream handshake
//   x_out, y_out       covered pixel coordinate
//   done_out           one-cycle pulse when a triangle's scan completes
module raster_tri_walker #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned COEF_W  = 12,
  parameter int unsigned ACC_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld_in,
  output logic               rdy_in,
  input  logic [COORD_W-1:0] xmin,
  input  logic [COORD_W-1:0] xmax,
  input  logic [COORD_W-1:0] ymin,
  input  logic [COORD_W-1:0] ymax,
  input  logic [COEF_W-1:0]  a0,
  input  logic [COEF_W-1:0]  b0,
  input  logic [COEF_W-1:0]  a1,
  input  logic [COEF_W-1:0]  b1,
  input  logic [COEF_W-1:0]  a2,
  input  logic [COEF_W-1:0]  b2,
  input  logic [ACC_W-1:0]   c0,
  input  logic [ACC_W-1:0]   c1,
  input  logic [ACC_W-1:0]   c2,
  output logic               vld_out,
  input  logic               rdy_out,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               done_out
);

  typedef enum logic [1:0] {StIdle, StSetup, StScan} state_e;

  state_e state_q, state_d;

  logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [2:0][COEF_W-1:0] a_q, b_q;
  logic [2:0][ACC_W-1:0]  c_q;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0][ACC_W-1:0] e_q, e_d, row_q, row_d;
  logic done_q, done_d;

  logic [2:0][ACC_W-1:0] a_ext, b_ext, start;
  logic covered, accept;

  function automatic logic [ACC_W-1:0] sext_coef(input logic [COEF_W-1:0] v);
    return {{(ACC_W-COEF_W){v[COEF_W-1]}}, v};
  endfunction

  function automatic logic [ACC_W-1:0] zext_coord(input logic [COORD_W-1:0] v);
    return {{(ACC_W-COORD_W){1'b0}}, v};
  endfunction

  // Row-start edge values at (xmin, ymin); the only multiplies in the block, used in setup.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      a_ext[i] = sext_coef(a_q[i]);
      b_ext[i] = sext_coef(b_q[i]);
      start[i] = a_ext[i] * zext_coord(xmin_q) + b_ext[i] * zext_coord(ymin_q) + c_q[i];
    end
  end

  // A pixel is covered when all three edge functions are non-negative (inclusive edges).
  assign covered = ~e_q[0][ACC_W-1] & ~e_q[1][ACC_W-1] & ~e_q[2][ACC_W-1];
  assign accept  = (state_q == StIdle) && vld_in;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    e_d     = e_q;
    row_d   = row_q;
    unique case (state_q)
      StIdle: begin
        if (vld_in) state_d = StSetup;
      end
      StSetup: begin
        x_d   = xmin_q;
        y_d   = ymin_q;
        e_d   = start;
        row_d = start;
        if ((xmin_q > xmax_q) || (ymin_q > ymax_q)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StScan;
        end
      end
      StScan: begin
        // Uncovered pixels are skipped without waiting on the consumer.
        if (!covered || rdy_out) begin
          if (x_q < xmax_q) begin
            // Compare-before-increment keeps x from wrapping when xmax is the top coordinate.
            x_d = x_q + 1'b1;
            for (int i = 0; i < 3; i++) e_d[i] = e_q[i] + a_ext[i];
          end else if (y_q < ymax_q) begin
            x_d = xmin_q;
            y_d = y_q + 1'b1;
            for (int i = 0; i < 3; i++) begin
              row_d[i] = row_q[i] + b_ext[i];
              e_d[i]   = row_q[i] + b_ext[i];
            end
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Datapath registers need no reset: they are only observed in setup/scan states.
  always_ff @(posedge clk) begin
    e_q   <= e_d;
    row_q <= row_d;
    if (accept) begin
      xmin_q <= xmin;
      xmax_q <= xmax;
      ymin_q <= ymin;
      ymax_q <= ymax;
      a_q    <= {a2, a1, a0};
      b_q    <= {b2, b1, b0};
      c_q    <= {c2, c1, c0};
    end
  end

  assign rdy_in   = (state_q == StIdle);
  assign vld_out  = (state_q == StScan) && covered;
  assign x_out    = x_q;
  assign y_out    = y_q;
  assign done_out = done_q;

endmodule

// File: tb/tb_raster_tri_walker.sv
// Self-checking bench for raster_tri_walker.
// Uses directed scenarios plus random triangles.
// Results are compared against a loop-based coverage model.
module tb_raster_tri_walker;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COEF_W  = 12;
  localparam int unsigned ACC_W   = 32;

  typedef struct {
    int xmin, xmax, ymin, ymax;
    int a0, b0, a1, b1, a2, b2;
    int c0, c1, c2;
  } tri_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               vld_in = 1'b0;
  logic               rdy_in;
  logic [COORD_W-1:0] xmin = '0, xmax = '0, ymin = '0, ymax = '0;
  logic [COEF_W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0, a2 = '0, b2 = '0;
  logic [ACC_W-1:0]   c0 = '0, c1 = '0, c2 = '0;
  logic               vld_out;
  logic               rdy_out = 1'b1;
  logic [COORD_W-1:0] x_out, y_out;
  logic               done_out;

  int n_tests = 0;
  int n_fail  = 0;

  raster_tri_walker #(.COORD_W(COORD_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (vld_in),
    .rdy_in  (rdy_in),
    .xmin    (xmin),
    .xmax    (xmax),
    .ymin    (ymin),
    .ymax    (ymax),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .a2      (a2),
    .b2      (b2),
    .c0      (c0),
    .c1      (c1),
    .c2      (c2),
    .vld_out (vld_out),
    .rdy_out (rdy_out),
    .x_out   (x_out),
    .y_out   (y_out),
    .done_out(done_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: brute-force evaluation of every box pixel, raster order.
  task automatic model(input tri_t t, output int qx[$], output int qy[$]);
    longint e0, e1, e2;
    qx = {};
    qy = {};
    for (int y = t.ymin; y <= t.ymax; y++) begin
      for (int x = t.xmin; x <= t.xmax; x++) begin
        e0 = longint'(t.a0) * x + longint'(t.b0) * y + t.c0;
        e1 = longint'(t.a1) * x + longint'(t.b1) * y + t.c1;
        e2 = longint'(t.a2) * x + longint'(t.b2) * y + t.c2;
        if (e0 >= 0 && e1 >= 0 && e2 >= 0) begin
          qx.push_back(x);
          qy.push_back(y);
        end
      end
    end
  endtask

  task automatic run_tri(input string name, input tri_t t, input bit rand_rdy,
                         input int abort_after);
    int qx[$], qy[$], gx[$], gy[$];
    int cyc, area, bound, stab_err, busy_err, done_cyc, done_cnt;
    bit stall_prev, degen;
    int px, py;
    model(t, qx, qy);
    degen    = (t.xmin > t.xmax) || (t.ymin > t.ymax);
    area     = degen ? 0 : (t.xmax - t.xmin + 1) * (t.ymax - t.ymin + 1);
    bound    = 4 * area + 40;
    stab_err = 0;
    busy_err = 0;
    done_cyc = -1;
    stall_prev = 1'b0;
    px = 0;
    py = 0;
    cyc = 0;

    @(negedge clk);
    check({name, ":rdy_in_idle"}, longint'(rdy_in), 1);
    xmin = COORD_W'(t.xmin); xmax = COORD_W'(t.xmax);
    ymin = COORD_W'(t.ymin); ymax = COORD_W'(t.ymax);
    a0 = COEF_W'(t.a0); b0 = COEF_W'(t.b0);
    a1 = COEF_W'(t.a1); b1 = COEF_W'(t.b1);
    a2 = COEF_W'(t.a2); b2 = COEF_W'(t.b2);
    c0 = ACC_W'(t.c0); c1 = ACC_W'(t.c1); c2 = ACC_W'(t.c2);
    vld_in = 1'b1;

    while (cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) vld_in = 1'b0;
      if (abort_after >= 0 && gx.size() == abort_after) begin
        for (int i = 0; i < abort_after; i++) begin
          check({name, ":pre_abort_x"}, gx[i], qx[i]);
          check({name, ":pre_abort_y"}, gy[i], qy[i]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({name, ":abort_vld_out"}, longint'(vld_out), 0);
        check({name, ":abort_rdy_in"}, longint'(rdy_in), 1);
        check({name, ":abort_done"}, longint'(done_out), 0);
        check({name, ":abort_x_out"}, longint'(x_out), 0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (done_out || vld_out) done_cnt++;
        end
        check({name, ":abort_quiet"}, done_cnt, 0);
        return;
      end
      if (stall_prev && (!vld_out || x_out != COORD_W'(px) || y_out != COORD_W'(py)))
        stab_err++;
      if (done_out) begin
        done_cyc = cyc;
        break;
      end
      if (rdy_in) busy_err++;
      rdy_out = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vld_out && rdy_out) begin
        gx.push_back(int'(x_out));
        gy.push_back(int'(y_out));
      end
      stall_prev = vld_out && !rdy_out;
      px = int'(x_out);
      py = int'(y_out);
    end
    rdy_out = 1'b1;

    check({name, ":done_seen"}, longint'(done_cyc >= 0), 1);
    if (done_cyc >= 0) begin
      check({name, ":done_rdy_in"}, longint'(rdy_in), 1);
      check({name, ":done_vld_out"}, longint'(vld_out), 0);
      if (!rand_rdy) check({name, ":done_latency"}, done_cyc, 2 + area);
      @(negedge clk);
      check({name, ":done_pulse"}, longint'(done_out), 0);
    end
    check({name, ":stable"}, stab_err, 0);
    check({name, ":busy_rdy_in"}, busy_err, 0);
    check({name, ":npix"}, gx.size(), qx.size());
    if (gx.size() == qx.size()) begin
      for (int i = 0; i < qx.size(); i++) begin
        check({name, ":pix_x"}, gx[i], qx[i]);
        check({name, ":pix_y"}, gy[i], qy[i]);
      end
    end
  endtask

  initial begin
    tri_t t;
    tri_t tri2;
    tri2 = '{xmin: 0, xmax: 3, ymin: 0, ymax: 3,
             a0: 1, b0: 0, a1: 0, b1: 1, a2: -1, b2: -1,
             c0: 0, c1: 0, c2: 3};

    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset:rdy_in", longint'(rdy_in), 1);
    check("reset:vld_out", longint'(vld_out), 0);
    check("reset:done_out", longint'(done_out), 0);
    check("reset:x_out", longint'(x_out), 0);
    check("reset:y_out", longint'(y_out), 0);

    run_tri("tri2", tri2, 1'b0, -1);
    run_tri("tri2_bp", tri2, 1'b1, -1);

    t = '{xmin: 5, xmax: 4, ymin: 0, ymax: 3, a0: 0, b0: 0, a1: 0, b1: 0, a2: 0, b2: 0,
          c0: 0, c1: 0, c2: 0};
    run_tri("degen_x", t, 1'b0, -1);
    t.xmin = 0; t.xmax = 3; t.ymin = 6; t.ymax = 2;
    run_tri("degen_y", t, 1'b0, -1);

    t = '{xmin: 7, xmax: 7, ymin: 9, ymax: 9, a0: 0, b0: 0, a1: 0, b1: 0, a2: 0, b2: 0,
          c0: 0, c1: 0, c2: 0};
    run_tri("single", t, 1'b0, -1);
    t.c2 = -1;
    run_tri("single_neg", t, 1'b0, -1);

    t = '{xmin: 1020, xmax: 1023, ymin: 1022, ymax: 1023,
          a0: 0, b0: 0, a1: 0, b1: 0, a2: 0, b2: 0, c0: 0, c1: 0, c2: 0};
    run_tri("corner", t, 1'b0, -1);
    run_tri("corner_bp", t, 1'b1, -1);

    run_tri("abort", tri2, 1'b0, 3);
    run_tri("after_abort", tri2, 1'b0, -1);

    for (int n = 0; n < 24; n++) begin
      t.xmin = int'($urandom_range(0, 12));
      t.xmax = t.xmin + int'($urandom_range(0, 5));
      t.ymin = int'($urandom_range(0, 12));
      t.ymax = t.ymin + int'($urandom_range(0, 5));
      t.a0 = int'($urandom_range(0, 14)) - 7;
      t.b0 = int'($urandom_range(0, 14)) - 7;
      t.a1 = int'($urandom_range(0, 14)) - 7;
      t.b1 = int'($urandom_range(0, 14)) - 7;
      t.a2 = int'($urandom_range(0, 14)) - 7;
      t.b2 = int'($urandom_range(0, 14)) - 7;
      t.c0 = int'($urandom_range(0, 80)) - 30;
      t.c1 = int'($urandom_range(0, 80)) - 30;
      t.c2 = int'($urandom_range(0, 80)) - 30;
      run_tri("rand", t, n[0], -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
